// File: rtl/plab4_net_domain_mux.sv
// plab4_net_domain_mux
//   Transmit-side merge of the two ring domains onto one tagged channel.
//   Each domain is buffered in a private queue; a work-conserving
//   round-robin arbiter with grant lock selects which queue head is driven
//   onto the shared output. out_domain tags the beat (0 = d1, 1 = d2).
//
//   Optional build macro:
//     PLAB4_NET_DOMAIN_MUX_TDM_EN - replaces round-robin with strict
//     time-division (slot toggles every cycle, out_domain = slot).
//
//   Ports:
//     clk, reset (async, active-low)
//     in_val_d1/in_rdy_d1/in_msg_control_d1/in_msg_data_d1  domain-1 input
//     in_val_d2/in_rdy_d2/in_msg_control_d2/in_msg_data_d2  domain-2 input
//     out_val/out_rdy/out_msg_control/out_msg_data/out_domain  merged output

// Per-domain queue: circular buffer with occupancy counter. No bypass, and
// a full queue refuses enqueue even if it dequeues in the same cycle.
module plab4_net_domain_mux_queue #(
  parameter int p_msg_cnbits  = 44,
  parameter int p_msg_dnbits  = 32,
  parameter int p_num_entries = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq_val,
  output logic                    enq_rdy,
  input  logic [p_msg_cnbits-1:0] enq_control,
  input  logic [p_msg_dnbits-1:0] enq_data,
  input  logic                    deq,
  output logic                    head_val,
  output logic [p_msg_cnbits-1:0] head_control,
  output logic [p_msg_dnbits-1:0] head_data
);

  localparam int CNT_W = $clog2(p_num_entries + 1);
  localparam int PTR_W = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

  logic [CNT_W-1:0]        cnt_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [p_msg_cnbits-1:0] mem_control [p_num_entries];
  logic [p_msg_dnbits-1:0] mem_data    [p_num_entries];
  logic                    enq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(p_num_entries - 1)) return '0;
    else                                  return ptr + PTR_W'(1);
  endfunction

  assign enq_rdy  = (cnt_q != CNT_W'(p_num_entries));
  assign head_val = (cnt_q != '0);
  assign enq      = enq_val & enq_rdy;

  assign head_control = mem_control[rd_ptr_q];
  assign head_data    = mem_data[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(enq) - CNT_W'(deq);
      if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Payload storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_control[wr_ptr_q] <= enq_control;
      mem_data[wr_ptr_q]    <= enq_data;
    end
  end

endmodule

module plab4_net_domain_mux #(
  parameter int p_msg_cnbits  = 44,
  parameter int p_msg_dnbits  = 32,
  parameter int p_num_entries = 2
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    in_val_d1,
  output logic                    in_rdy_d1,
  input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
  input  logic [p_msg_dnbits-1:0] in_msg_data_d1,

  input  logic                    in_val_d2,
  output logic                    in_rdy_d2,
  input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
  input  logic [p_msg_dnbits-1:0] in_msg_data_d2,

  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [p_msg_cnbits-1:0] out_msg_control,
  output logic [p_msg_dnbits-1:0] out_msg_data,
  output logic                    out_domain
);

  logic                    ne_d1, ne_d2;
  logic [p_msg_cnbits-1:0] head_control_d1, head_control_d2;
  logic [p_msg_dnbits-1:0] head_data_d1, head_data_d2;
  logic                    grant;
  logic                    xfer;
  logic                    deq_d1, deq_d2;

  plab4_net_domain_mux_queue #(
    .p_msg_cnbits (p_msg_cnbits),
    .p_msg_dnbits (p_msg_dnbits),
    .p_num_entries(p_num_entries)
  ) u_queue_d1 (
    .clk         (clk),
    .reset       (reset),
    .enq_val     (in_val_d1),
    .enq_rdy     (in_rdy_d1),
    .enq_control (in_msg_control_d1),
    .enq_data    (in_msg_data_d1),
    .deq         (deq_d1),
    .head_val    (ne_d1),
    .head_control(head_control_d1),
    .head_data   (head_data_d1)
  );

  plab4_net_domain_mux_queue #(
    .p_msg_cnbits (p_msg_cnbits),
    .p_msg_dnbits (p_msg_dnbits),
    .p_num_entries(p_num_entries)
  ) u_queue_d2 (
    .clk         (clk),
    .reset       (reset),
    .enq_val     (in_val_d2),
    .enq_rdy     (in_rdy_d2),
    .enq_control (in_msg_control_d2),
    .enq_data    (in_msg_data_d2),
    .deq         (deq_d2),
    .head_val    (ne_d2),
    .head_control(head_control_d2),
    .head_data   (head_data_d2)
  );

`ifdef PLAB4_NET_DOMAIN_MUX_TDM_EN
  // Strict time-division: each domain owns every other cycle regardless of
  // the other's traffic, so d2 load cannot perturb d1 timing.
  logic slot_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slot_q <= 1'b0;
    else        slot_q <= ~slot_q;
  end

  assign grant = slot_q;
`else
  logic prio_q;
  logic lock_q;
  logic lock_grant_q;
  logic rr_grant;

  // Priority domain first, otherwise the other if it has work. When both
  // are empty the grant rests on d1 so the idle tag reads 0.
  assign rr_grant = ne_d2 & (prio_q | ~ne_d1);

  // A stalled offer keeps its domain until it transfers; a queue that
  // becomes non-empty meanwhile cannot steal the channel.
  assign grant = lock_q ? lock_grant_q : rr_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q       <= 1'b0;
      lock_q       <= 1'b0;
      lock_grant_q <= 1'b0;
    end else if (xfer) begin
      prio_q <= ~grant;
      lock_q <= 1'b0;
    end else if (out_val) begin
      lock_q       <= 1'b1;
      lock_grant_q <= grant;
    end
  end
`endif

  assign out_val    = grant ? ne_d2 : ne_d1;
  assign out_domain = grant;
  assign xfer       = out_val & out_rdy;
  assign deq_d1     = xfer & ~grant;
  assign deq_d2     = xfer & grant;

  // Payload is zeroed whenever nothing is offered so neither domain's stale
  // queue contents ever appear on the shared link.
  assign out_msg_control = !out_val ? '0 : (grant ? head_control_d2 : head_control_d1);
  assign out_msg_data    = !out_val ? '0 : (grant ? head_data_d2    : head_data_d1);

endmodule

// File: tb/tb_plab4_net_domain_mux.sv
module tb_plab4_net_domain_mux;

  localparam int CN = 44;
  localparam int DN = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_val_d1 = 1'b0, in_val_d2 = 1'b0;
  logic          in_rdy_d1, in_rdy_d2;
  logic [CN-1:0] in_msg_control_d1 = '0, in_msg_control_d2 = '0;
  logic [DN-1:0] in_msg_data_d1 = '0, in_msg_data_d2 = '0;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [CN-1:0] out_msg_control;
  logic [DN-1:0] out_msg_data;
  logic          out_domain;

  int n_checks = 0;
  int n_pass   = 0;

  plab4_net_domain_mux #(
    .p_msg_cnbits (CN),
    .p_msg_dnbits (DN),
    .p_num_entries(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_val_d1        (in_val_d1),
    .in_rdy_d1        (in_rdy_d1),
    .in_msg_control_d1(in_msg_control_d1),
    .in_msg_data_d1   (in_msg_data_d1),
    .in_val_d2        (in_val_d2),
    .in_rdy_d2        (in_rdy_d2),
    .in_msg_control_d2(in_msg_control_d2),
    .in_msg_data_d2   (in_msg_data_d2),
    .out_val          (out_val),
    .out_rdy          (out_rdy),
    .out_msg_control  (out_msg_control),
    .out_msg_data     (out_msg_data),
    .out_domain       (out_domain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_val_d1 = 1'b0; in_val_d2 = 1'b0;
    in_msg_control_d1 = '0; in_msg_data_d1 = '0;
    in_msg_control_d2 = '0; in_msg_data_d2 = '0;
  endtask

  // Called 1ns after an edge; leaves reset released before the next edge.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic send_d1(input logic [CN-1:0] c, input logic [DN-1:0] d);
    in_val_d1 = 1'b1; in_msg_control_d1 = c; in_msg_data_d1 = d;
  endtask

  task automatic send_d2(input logic [CN-1:0] c, input logic [DN-1:0] d);
    in_val_d2 = 1'b1; in_msg_control_d2 = c; in_msg_data_d2 = d;
  endtask

  initial begin
    int i1, i2, k;
    logic acc1, acc2;

    // Reset state
    #2;
    check("rst_rdy_d1", in_rdy_d1, 1);
    check("rst_rdy_d2", in_rdy_d2, 1);
    check("rst_out_val", out_val, 0);
    check("rst_domain", out_domain, 0);
    check("rst_data", out_msg_data, 0);
    check("rst_control", out_msg_control, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // Single d1 message, latency one cycle
    out_rdy = 1'b1;
    send_d1(44'h11, 32'hA5);
    cyc();
    idle_inputs();
    #1;
    check("t1_val", out_val, 1);
    check("t1_domain", out_domain, 0);
    check("t1_data", out_msg_data, 32'hA5);
    check("t1_control", out_msg_control, 44'h11);
    cyc();
    check("t1_val_after", out_val, 0);
    check("t1_data_after", out_msg_data, 0);

    // Both domains streaming: alternating d1,d2 with order preserved
    do_reset();
    out_rdy = 1'b1;
    i1 = 0; i2 = 0; k = 0;
    for (int c = 0; c < 30 && k < 8; c++) begin
      in_val_d1 = (i1 < 4); in_msg_data_d1 = 32'hA0 + i1; in_msg_control_d1 = 44'h100 + i1;
      in_val_d2 = (i2 < 4); in_msg_data_d2 = 32'hB0 + i2; in_msg_control_d2 = 44'h200 + i2;
      #1;
      acc1 = in_val_d1 & in_rdy_d1;
      acc2 = in_val_d2 & in_rdy_d2;
      if (out_val) begin
        check("t2_domain", out_domain, k % 2);
        check("t2_data", out_msg_data, (k % 2 ? 32'hB0 : 32'hA0) + k / 2);
        check("t2_control", out_msg_control, (k % 2 ? 44'h200 : 44'h100) + k / 2);
        k++;
      end
      @(posedge clk); #1;
      if (acc1) i1++;
      if (acc2) i2++;
    end
    idle_inputs();
    check("t2_count", k, 8);
    #1;
    check("t2_drained", out_val, 0);

    // Backpressure: d1 fills, third d1 message refused, lock holds d1
    cyc();
    do_reset();
    out_rdy = 1'b0;
    send_d1(44'h31, 32'h31);
    cyc();
    send_d1(44'h32, 32'h32);
    send_d2(44'h41, 32'h41);
    cyc();
    in_val_d2 = 1'b0;
    send_d1(44'h33, 32'h33);
    #1;
    check("t3_rdy_d1_full", in_rdy_d1, 0);
    check("t3_rdy_d2", in_rdy_d2, 1);
    check("t3_domain_locked", out_domain, 0);
    check("t3_head", out_msg_data, 32'h31);
    cyc();
    idle_inputs();
    out_rdy = 1'b1;
    #1;
    check("t3_x0_domain", out_domain, 0);
    check("t3_x0_data", out_msg_data, 32'h31);
    cyc();
    check("t3_x1_domain", out_domain, 1);
    check("t3_x1_data", out_msg_data, 32'h41);
    cyc();
    check("t3_x2_domain", out_domain, 0);
    check("t3_x2_data", out_msg_data, 32'h32);
    cyc();
    check("t3_no_third", out_val, 0);

    // Grant lock on d2 against a higher-priority d1 arrival
    do_reset();
    out_rdy = 1'b0;
    send_d2(44'h52, 32'h52);
    cyc();
    idle_inputs();
    send_d1(44'h61, 32'h61);
    #1;
    check("t4_d2_offer", out_domain, 1);
    cyc();
    idle_inputs();
    #1;
    check("t4_lock_domain", out_domain, 1);
    check("t4_lock_data", out_msg_data, 32'h52);
    out_rdy = 1'b1;
    cyc();
    check("t4_next_domain", out_domain, 0);
    check("t4_next_data", out_msg_data, 32'h61);
    cyc();
    check("t4_empty", out_val, 0);

    // Reset asserted with both queues full
    do_reset();
    out_rdy = 1'b0;
    send_d1(44'h81, 32'h81); send_d2(44'h91, 32'h91);
    cyc();
    send_d1(44'h82, 32'h82); send_d2(44'h92, 32'h92);
    cyc();
    idle_inputs();
    #1;
    check("t5_full_d1", in_rdy_d1, 0);
    check("t5_full_d2", in_rdy_d2, 0);
    check("t5_val_before", out_val, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_val", out_val, 0);
    check("t5_rst_rdy_d1", in_rdy_d1, 1);
    check("t5_rst_rdy_d2", in_rdy_d2, 1);
    check("t5_rst_data", out_msg_data, 0);
    reset = 1'b1;
    out_rdy = 1'b1;
    cyc();
    check("t5_no_residual_a", out_val, 0);
    cyc();
    check("t5_no_residual_b", out_val, 0);

`ifdef PLAB4_NET_DOMAIN_MUX_TDM_EN
    // TDM: d1 only served in even slots
    do_reset();
    out_rdy = 1'b1;
    send_d1(44'h71, 32'h71);
    cyc();
    send_d1(44'h72, 32'h72);
    #1;
    check("tdm_c1_val", out_val, 0);
    check("tdm_c1_dom", out_domain, 1);
    cyc();
    idle_inputs();
    #1;
    check("tdm_c2_val", out_val, 1);
    check("tdm_c2_data", out_msg_data, 32'h71);
    check("tdm_c2_dom", out_domain, 0);
    cyc();
    check("tdm_c3_val", out_val, 0);
    cyc();
    check("tdm_c4_val", out_val, 1);
    check("tdm_c4_data", out_msg_data, 32'h72);
    cyc();
    check("tdm_c5_val", out_val, 0);
    cyc();
    check("tdm_c6_val", out_val, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/plab4_net_domain_mux.md
# plab4_net_domain_mux

Two-domain merge stage for the domain-separated ring: accepts messages on a domain-1 channel and a domain-2 channel, buffers each in a private queue, and arbitrates them onto one shared channel that carries a domain tag. It sits between a router's output and the link, as the transmit-side counterpart of the per-domain demux at the receiving router. Control and data payloads are kept separate; data beats are labelled by the domain they entered on.

## Interface
Parameters:
- p_msg_cnbits, 44: control message width (`VC_NET_MSG_NBITS` of control payload).
- p_msg_dnbits, 32: data payload width.
- p_num_entries, 2: depth of each per-domain queue, ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; one clock, no other resets.
- in_val_d1  in  1  domain-1 message valid.
- in_rdy_d1  out  1  domain-1 queue not full.
- in_msg_control_d1  in  p_msg_cnbits  domain-1 control.
- in_msg_data_d1  in  p_msg_dnbits  domain-1 data (label D1).
- in_val_d2 / in_rdy_d2 / in_msg_control_d2 / in_msg_data_d2: same, domain 2 (data label D2).
- out_val  out  1  merged message valid.
- out_rdy  in  1  downstream accepts.
- out_msg_control  out  p_msg_cnbits  merged control.
- out_msg_data  out  p_msg_dnbits  merged data, labelled by out_domain.
- out_domain  out  1  0 = message from d1, 1 = from d2.

## Operation
- Each input has its own FIFO of p_num_entries entries (control+data). Enqueue when in_val_dX & in_rdy_dX. in_rdy_dX = !full_dX; no bypass, no enqueue into a full queue even if it dequeues the same cycle.
- Occupancy counter width $clog2(p_num_entries+1); pointers wrap modulo p_num_entries.
- Arbiter (default, work-conserving round-robin): priority register prio (0 = d1). Grant = prio domain if its queue non-empty, else the other if non-empty. On out_val & out_rdy, dequeue granted queue, prio ← other domain.
- Grant lock: if out_val & !out_rdy, grant and out_domain are registered and held until transfer; a newly non-empty higher-priority queue does not steal.
- out_val = granted queue non-empty. out_msg_control/out_msg_data = granted queue head when out_val, else forced to 0 (no stale data from either domain exposed).
- Domains never mix within a queue; a D1 entry is only ever driven with out_domain=0.

## Timing
- Reset (asserted, asynchronously): both queues empty, prio=0, lock clear, TDM slot=0. Outputs: in_rdy_d1=in_rdy_d2=1, out_val=0, out_domain=0, out_msg_control=0, out_msg_data=0.
- Latency: enqueue at edge N → out_val earliest in cycle N+1 (combinational from queue head).
- Throughput: one transfer per cycle when out_rdy held high.
- Simultaneous enqueue on both inputs: both accepted if not full.
- Simultaneous enqueue and dequeue on same non-full queue: count unchanged.
- Reset asserted mid-transfer: all queued messages discarded, outputs go to reset values immediately.

## Configuration
- PLAB4_NET_DOMAIN_MUX_TDM_EN defined: arbitration replaced by strict time-division. Slot register toggles every cycle (0,1,0,1…) from reset. out_domain = slot; out_val = slot queue non-empty; dequeue only from slot queue. Not work-conserving, no grant lock (out_val may drop when slot changes); d2 traffic cannot modulate d1 timing.
- Undefined: round-robin with grant lock as in Operation.

## Test plan
- Reset, then d1 sends control 0x11/data 0xA5 in cycle 1, out_rdy=1 → cycle 2 out_val=1, out_domain=0, out_msg_data=0xA5; cycle 3 out_val=0, data=0.
- Both inputs enqueue every cycle, out_rdy=1 → outputs alternate d1,d2,d1,d2 starting with d1; no loss, per-domain order preserved.
- out_rdy=0, fill d1 with 2 entries → in_rdy_d1=0 at cycle 3; third in_val_d1 ignored; d2 enqueue meanwhile does not change locked out_domain=0.
- Hold out_rdy=0 with d2 granted, then d1 enqueues → out_domain stays 1 until out_rdy=1 transfer, then next grant d1.
- TDM build: only d1 traffic, queue non-empty, out_rdy=1 → one transfer every other cycle (even slots), out_val=0 on odd cycles.
- Assert reset with both queues full → same cycle out_val=0, in_rdy_d1/d2=1; after release no residual messages appear.
